// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared address-map constants and target decode for the data-memory
//           MMIO responder.
// Rev     : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam int         MMIO_BIT   = 31;
    localparam logic [1:0] OFF_LED    = 2'd0;
    localparam logic [1:0] OFF_STREAM = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [7:0] OVF_MAX    = 8'hFF;

    typedef enum logic [2:0] {
        SEL_RAM    = 3'd0,
        SEL_LED    = 3'd1,
        SEL_STREAM = 3'd2,
        SEL_STATUS = 3'd3,
        SEL_NONE   = 3'd4
    } sel_t;

    function automatic sel_t decode_sel(input logic is_mmio, input logic [1:0] offset);
        sel_t sel;
        sel = SEL_RAM;
        if (is_mmio) begin
            case (offset)
                OFF_LED:    sel = SEL_LED;
                OFF_STREAM: sel = SEL_STREAM;
                OFF_STATUS: sel = SEL_STATUS;
                default:    sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO; a push at full is accepted only when a pop
//           frees a slot in the same cycle.
// Rev     : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Storage is not reset; only pointers and occupancy carry state.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_mmio_responder
// Brief   : Data-memory store responder: word RAM plus LED/stream/status MMIO.
//           Optional write trace enabled by defining DMEM_MMIO_TRACE_EN.
// Rev     : 1.0  initial release
// ============================================================================
module dmem_mmio_responder
    import dmem_pkg::*;
#(
    parameter int RAM_AW     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LED_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_data,
    input  logic              mem_we,
    output logic [31:0]       rd_data,
    output logic [LED_W-1:0]  leds,
    output logic              out_valid,
    output logic [31:0]       out_data,
    input  logic              out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       r_ram [2**RAM_AW];
    logic [LED_W-1:0]  r_leds;
    logic [7:0]        r_ovf;

    sel_t              w_sel;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf;
    logic [CW-1:0]     w_count;
    logic [3:0]        w_cnt4;
    logic              w_unused_addr;

    assign w_sel         = decode_sel(mem_addr[MMIO_BIT], mem_addr[1:0]);
    assign w_ram_idx     = mem_addr[RAM_AW-1:0];
    assign w_unused_addr = ^mem_addr[30:RAM_AW];
    assign w_push        = mem_we && (w_sel == SEL_STREAM);
    assign w_pop         = out_valid && out_ready;
    assign w_ovf         = w_push && w_full && !w_pop;
    assign w_cnt4        = 4'(w_count);
    assign out_valid     = !w_empty;
    assign leds          = r_leds;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (mem_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (out_data)
    );

    // RAM survives reset so a soft restart keeps data memory intact.
    always_ff @(posedge clk) begin
        if (mem_we && (w_sel == SEL_RAM)) begin
            r_ram[w_ram_idx] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds <= '0;
            r_ovf  <= '0;
        end else begin
            if (mem_we && (w_sel == SEL_LED)) begin
                r_leds <= mem_data[LED_W-1:0];
            end
            if (w_ovf && (r_ovf != OVF_MAX)) begin
                r_ovf <= r_ovf + 8'd1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (w_sel)
            SEL_RAM:    rd_data = r_ram[w_ram_idx];
            SEL_LED:    rd_data = 32'(r_leds);
            SEL_STATUS: rd_data = {16'b0, r_ovf, 4'b0, w_cnt4};
            default:    rd_data = '0;
        endcase
    end

`ifdef DMEM_MMIO_TRACE_EN
    always @(posedge clk) begin
        if (rst_n && mem_we) begin
            case (w_sel)
                SEL_RAM:    $strobe("DMEM: [%h] %h RAM", mem_addr, mem_data);
                SEL_LED:    $strobe("DMEM: [%h] %h LED", mem_addr, mem_data);
                SEL_STREAM: begin
                    if (w_ovf) begin
                        $strobe("DMEM: stream overflow %0d", r_ovf);
                    end else begin
                        $strobe("DMEM: [%h] %h STREAM", mem_addr, mem_data);
                    end
                end
                default: ;
            endcase
        end
    end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_mmio_responder
// Brief   : Self-checking bench: directed scenarios then random stores/drains
//           against a queue/array reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_mmio_responder;

    localparam int RAM_AW     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int LED_W      = 8;

    logic             clk;
    logic             rst_n;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
    logic             mem_we;
    logic [31:0]      rd_data;
    logic [LED_W-1:0] leds;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready;

    dmem_mmio_responder #(
        .RAM_AW     (RAM_AW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LED_W      (LED_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .rd_data   (rd_data),
        .leds      (leds),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] A_LED    = 32'h8000_0000;
    localparam logic [31:0] A_STREAM = 32'h8000_0001;
    localparam logic [31:0] A_STATUS = 32'h8000_0002;
    localparam logic [31:0] A_RSVD   = 32'h8000_0003;

    // Reference model state
    logic [31:0] m_ram [0:255];
    bit          m_wr  [0:255];
    logic [31:0] m_q [$];
    logic [7:0]  m_leds;
    logic [7:0]  m_ovf;

    int          n_vec;
    int          n_err;
    logic [31:0] obs_rd;
    logic [31:0] obs_data;
    logic        obs_valid;
    logic [7:0]  obs_leds;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_rd(input logic [31:0] a, output logic [31:0] v);
        logic [7:0] idx;
        logic [1:0] off;
        int         cnt;
        idx = a[7:0];
        off = a[1:0];
        cnt = m_q.size();
        v   = 32'h0;
        if (!a[31]) begin
            v = m_ram[idx];
            return m_wr[idx];
        end
        if (off == 2'd0) v = {24'h0, m_leds};
        else if (off == 2'd2) v = (32'(m_ovf) << 8) + 32'(cnt);
        return 1'b1;
    endfunction

    // One bus cycle: drive at negedge, compare mid-cycle, advance model at posedge.
    task automatic step(input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic rdy);
        logic [31:0] ev;
        bit          known;
        bit          pop;
        bit          acc;
        logic [7:0]  idx;
        @(negedge clk);
        mem_addr  = a;
        mem_data  = d;
        mem_we    = we;
        out_ready = rdy;
        #1;
        obs_rd    = rd_data;
        obs_data  = out_data;
        obs_valid = out_valid;
        obs_leds  = leds;
        known = model_rd(a, ev);
        if (known) chk("rd_data", rd_data, ev);
        chk("leds", {24'h0, leds}, {24'h0, m_leds});
        chk("out_valid", {31'h0, out_valid}, (m_q.size() > 0) ? 32'h1 : 32'h0);
        if (m_q.size() > 0) chk("out_data", out_data, m_q[0]);
        @(posedge clk);
        idx = a[7:0];
        pop = (m_q.size() > 0) && rdy;
        acc = (m_q.size() < FIFO_DEPTH) || pop;
        if (pop) void'(m_q.pop_front());
        if (we) begin
            if (!a[31]) begin
                m_ram[idx] = d;
                m_wr[idx]  = 1'b1;
            end else if (a[1:0] == 2'd0) begin
                m_leds = d[7:0];
            end else if (a[1:0] == 2'd1) begin
                if (acc) m_q.push_back(d);
                else if (m_ovf < 8'd255) m_ovf = m_ovf + 8'd1;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          kind;
        n_vec     = 0;
        n_err     = 0;
        m_leds    = 8'h0;
        m_ovf     = 8'h0;
        for (int i = 0; i < 256; i++) begin
            m_ram[i] = 32'h0;
            m_wr[i]  = 1'b0;
        end
        rst_n     = 1'b0;
        mem_addr  = A_STATUS;
        mem_data  = 32'h0;
        mem_we    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_leds", {24'h0, leds}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("status_rst", obs_rd, 32'h0);

        // RAM store and alias
        step(32'h0000_0005, 32'hDEAD_BEEF, 1'b1, 1'b0);
        step(32'h0000_0105, 32'h1234_5678, 1'b1, 1'b0);
        step(32'h0000_0005, 32'h0, 1'b0, 1'b0);
        chk("ram_alias", obs_rd, 32'h1234_5678);
        chk("ram_leds", {24'h0, obs_leds}, 32'h0);

        // LED register and reserved offset
        step(A_LED, 32'h0000_01A5, 1'b1, 1'b0);
        step(A_LED, 32'h0, 1'b0, 1'b0);
        chk("led_val", {24'h0, obs_leds}, 32'hA5);
        chk("led_rd", obs_rd, 32'hA5);
        step(A_RSVD, 32'hFF, 1'b1, 1'b0);
        step(A_RSVD, 32'h0, 1'b0, 1'b0);
        chk("rsvd_rd", obs_rd, 32'h0);
        chk("rsvd_led", {24'h0, obs_leds}, 32'hA5);

        // Stream ordering
        for (int i = 1; i <= 3; i++) step(A_STREAM, 32'(i), 1'b1, 1'b0);
        step(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("strm_valid", {31'h0, obs_valid}, 32'h1);
        chk("strm_head", obs_data, 32'h1);
        chk("strm_count", obs_rd, 32'h3);
        for (int i = 1; i <= 3; i++) begin
            step(A_STATUS, 32'h0, 1'b0, 1'b1);
            chk("strm_drain", obs_data, 32'(i));
        end
        step(A_STATUS, 32'h0, 1'b0, 1'b1);
        chk("strm_empty", {31'h0, obs_valid}, 32'h0);

        // Overflow at full, then push-with-pop at full
        for (int i = 0; i < 5; i++) step(A_STREAM, 32'h10 + 32'(i), 1'b1, 1'b0);
        step(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("ovf_status", obs_rd, 32'h0000_0104);
        step(A_STREAM, 32'h20, 1'b1, 1'b1);
        step(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("full_pushpop", obs_rd, 32'h0000_0104);
        chk("full_head", obs_data, 32'h11);

        // Saturation
        for (int i = 0; i < 300; i++) step(A_STREAM, $urandom, 1'b1, 1'b0);
        step(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("ovf_sat", obs_rd, 32'h0000_FF04);
        step(A_STREAM, 32'h77, 1'b1, 1'b0);
        step(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("ovf_hold", obs_rd, 32'h0000_FF04);

        // Mid-operation asynchronous reset
        step(32'h0000_0020, 32'hCAFE_F00D, 1'b1, 1'b0);
        step(A_STATUS, 32'h0, 1'b0, 1'b1);
        step(A_STATUS, 32'h0, 1'b0, 1'b1);
        step(A_LED, 32'h3C, 1'b1, 1'b0);
        step(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_status", obs_rd, 32'h0000_FF02);
        chk("pre_rst_leds", {24'h0, obs_leds}, 32'h3C);
        @(negedge clk);
        mem_we    = 1'b0;
        mem_addr  = A_STATUS;
        out_ready = 1'b0;
        #1 rst_n  = 1'b0;
        #1;
        chk("arst_valid", {31'h0, out_valid}, 32'h0);
        chk("arst_leds", {24'h0, leds}, 32'h0);
        chk("arst_status", rd_data, 32'h0);
        m_q.delete();
        m_leds = 8'h0;
        m_ovf  = 8'h0;
        #1 rst_n = 1'b1;
        step(32'h0000_0020, 32'h0, 1'b0, 1'b0);
        chk("ram_keep", obs_rd, 32'hCAFE_F00D);
        step(A_STATUS, 32'h0, 1'b0, 1'b0);
        chk("post_rst_status", obs_rd, 32'h0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            kind = int'($urandom_range(0, 9));
            d    = $urandom;
            if (kind < 4) a = ($urandom & 32'h7FFF_FF00) | 32'($urandom_range(0, 15));
            else if (kind < 8) a = ($urandom & 32'h7FFF_FFFC) | A_STREAM;
            else a = ($urandom & 32'h7FFF_FFFC) | 32'h8000_0000 | 32'($urandom_range(0, 3));
            step(a, d, 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder end of the core's data-memory write interface. Every cycle it accepts the core's store (mem_addr, mem_data, mem_we) with no stall, since the core has no ready input.
- Decodes the address into a word RAM or a small MMIO window: an LED register, a posted output-stream FIFO and a status word.
- Drives a combinational read port for future load instructions, and a valid/ready output stream drained by a downstream consumer (console or debug sink).

Parameters:
- RAM_AW, 8, word-address width of data RAM (2^RAM_AW 32-bit words)
- FIFO_DEPTH, 4, stream FIFO entries; power of two, >= 2
- LED_W, 8, width of LED output register

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_addr  in  32  word address from core (word-addressed, not byte)
- mem_data  in  32  store data from core
- mem_we  in  1  store strobe, one store per asserted cycle
- rd_data  out  32  combinational read data for mem_addr
- leds  out  LED_W  LED register contents
- out_valid  out  1  stream FIFO non-empty
- out_data  out  32  stream FIFO head word
- out_ready  in  1  consumer accepts head when out_valid && out_ready

Behaviour:
- Interface: one clock, clk; reset asynchronous active-low, rst_n.
- Address decode:
  - mem_addr[31]==0 → RAM, index mem_addr[RAM_AW-1:0]; higher bits ignored (aliasing).
  - mem_addr[31]==1 → MMIO, selected by mem_addr[1:0]:
    - 0 = LED: write sets leds <= mem_data[LED_W-1:0]; reads return zero-extended leds.
    - 1 = STREAM: write pushes mem_data; reads return 0.
    - 2 = STATUS (read-only): {16'b0, ovf_cnt[7:0], 4'b0, count[3:0]}; writes ignored.
    - 3 = reserved: writes ignored, reads return 0.
- RAM writes occur on the rising edge when mem_we=1. Reads are combinational; a same-address write becomes visible the cycle after.
- RAM contents are not reset; the bench must not read unwritten words.
- Stream FIFO:
  - push = mem_we && STREAM selected; pop = out_valid && out_ready.
  - Push is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and pop occurs in the same cycle.
  - Simultaneous push and pop: count unchanged.
  - out_data is the head entry, stable while out_valid && !out_ready.
  - A push into an empty FIFO gives out_valid=1 the next cycle; there is no bypass.
  - Pointers wrap modulo FIFO_DEPTH. count has log2(FIFO_DEPTH)+1 bits and is zero-extended to 4 bits in STATUS.
- Overflow: a rejected push drops the data, leaves FIFO state untouched and increments ovf_cnt. ovf_cnt saturates at 255 and clears only on reset.
- Reset (asynchronous, any cycle including mid-drain):
  - leds=0, FIFO pointers and count = 0, ovf_cnt=0.
  - out_valid=0 immediately on assertion of rst_n=0. out_data is don't-care while out_valid=0.
  - RAM contents are unchanged by reset.
- Latency: store to leds / FIFO / RAM takes effect at the next edge. Stream latency from push to out_valid is 1 cycle.

Optional Feature:
- Macro: DMEM_MMIO_TRACE_EN.
- Defined: each accepted write prints via $strobe "DMEM: [addr] data target", where target is RAM/LED/STREAM. Each overflow prints "DMEM: stream overflow n", where n is the new ovf_cnt.
- Undefined: no simulation output. RTL behaviour is identical in both cases.

Decomposition:
- Package dmem_pkg:
  - MMIO base bit (31)
  - register offsets LED=2'd0, STREAM=2'd1, STATUS=2'd2
  - target-select enum {SEL_RAM, SEL_LED, SEL_STREAM, SEL_STATUS, SEL_NONE}
  - OVF_MAX=8'hFF
- Sub-module sync_fifo (WIDTH, DEPTH): push/pop/full/empty/count/head, asynchronous active-low reset. The top level holds decode, the LED register, RAM and ovf_cnt.

Test Plan:
- RAM store/load: write 0xDEADBEEF to addr 0x5, then 0x12345678 to addr 0x105 with RAM_AW=8 → rd_data at addr 0x5 reads 0x12345678 (alias); leds unchanged.
- LED: write 0x000001A5 to 0x80000000 → leds=0xA5 next cycle; rd_data at that address = 0x000000A5; write to 0x80000003 → no change.
- Stream order: out_ready=0, push 1,2,3 → out_valid=1, out_data=1, STATUS count=3; raise out_ready → outputs 1,2,3 on consecutive cycles, then out_valid=0.
- Overflow/wrap: out_ready=0, push 5 words into depth-4 → word 5 dropped, ovf_cnt=1, STATUS=0x00000104; a push with out_ready=1 at full is accepted, count stays 4.
- Saturation: 300 rejected pushes → ovf_cnt=255 and holds.
- Reset mid-operation: FIFO count=2, leds=0x3C; pulse rst_n low between edges → out_valid=0 and leds=0 immediately; STATUS=0; previously written RAM word still reads back.
